// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: up to STEP bits per clock, result held under out_valid/out_ready backpressure.
// Optional flag outputs (carry, zero) are built only when SEQ_SHIFTER_FLAGS_EN is defined.
module seq_shifter #(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
`ifdef SEQ_SHIFTER_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic             busy
);

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_cnt_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;

    logic [SHW-1:0]   w_k;
    logic [WIDTH-1:0] w_step_res;

`ifdef SEQ_SHIFTER_FLAGS_EN
    logic             r_carry;
    logic             w_carry_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             w_step_carry;
`endif

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [2:0] o);
        logic [WIDTH-1:0] res;
        res = v;
        case (o)
            OP_SHL:  res = {v[WIDTH-2:0], 1'b0};
            OP_SHR:  res = {1'b0, v[WIDTH-1:1]};
            OP_SAR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  res = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  res = {v[0], v[WIDTH-1:1]};
            default: res = v;
        endcase
        return res;
    endfunction

    // Left-moving ops lose the MSB, right-moving ops lose the LSB.
    function automatic logic carry1(input logic [WIDTH-1:0] v, input logic [2:0] o);
        return (o == OP_SHL || o == OP_ROL) ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        w_k        = (r_cnt < STEP_K) ? r_cnt : STEP_K;
        w_step_res = r_res;
`ifdef SEQ_SHIFTER_FLAGS_EN
        w_step_carry = r_carry;
`endif
        for (int j = 0; j < STEP; j++) begin
            if (SHW'(j) < w_k) begin
`ifdef SEQ_SHIFTER_FLAGS_EN
                w_step_carry = carry1(w_step_res, r_op);
`endif
                w_step_res = shift1(w_step_res, r_op);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_res_nxt       = r_res;
        w_op_nxt        = r_op;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
`ifdef SEQ_SHIFTER_FLAGS_EN
        w_carry_nxt     = r_carry;
        w_zero_nxt      = r_zero;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_res_nxt = a;
                    w_op_nxt  = op;
                    w_cnt_nxt = b;
`ifdef SEQ_SHIFTER_FLAGS_EN
                    w_carry_nxt = 1'b0;
`endif
                    if (b == '0 || op > OP_ROR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_res_nxt = w_step_res;
                w_cnt_nxt = r_cnt - w_k;
`ifdef SEQ_SHIFTER_FLAGS_EN
                w_carry_nxt = w_step_carry;
`endif
                if (r_cnt == w_k) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE cycle registers out_valid (and zero) so outputs come straight from flops.
                if (!r_out_valid) begin
                    w_out_valid_nxt = 1'b1;
`ifdef SEQ_SHIFTER_FLAGS_EN
                    w_zero_nxt = (r_res == '0);
`endif
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_res       <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef SEQ_SHIFTER_FLAGS_EN
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_res       <= w_res_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef SEQ_SHIFTER_FLAGS_EN
            r_carry     <= w_carry_nxt;
            r_zero      <= w_zero_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign r         = r_res;
`ifdef SEQ_SHIFTER_FLAGS_EN
    assign carry     = r_carry;
    assign zero      = r_zero;
`endif

    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_res)));

    a_valid_only_done: assert property (@(posedge clk) disable iff (rst)
        r_out_valid |-> (r_state == S_DONE));

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: random and directed requests against a plain-arithmetic model.
module tb_seq_shifter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [2:0] b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] r;
    logic       busy;

    logic       s3_in_valid, s3_in_ready;
    logic [2:0] s3_op;
    logic [7:0] s3_a;
    logic [2:0] s3_b;
    logic       s3_out_valid;
    logic       s3_out_ready;
    logic [7:0] s3_r;
    logic       s3_busy;

`ifdef SEQ_SHIFTER_FLAGS_EN
    logic       carry, zero, s3_carry, s3_zero;
`endif

    seq_shifter #(.WIDTH(8), .STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .r(r),
`ifdef SEQ_SHIFTER_FLAGS_EN
        .carry(carry), .zero(zero),
`endif
        .busy(busy)
    );

    seq_shifter #(.WIDTH(8), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .op(s3_op), .a(s3_a), .b(s3_b), .out_valid(s3_out_valid), .out_ready(s3_out_ready), .r(s3_r),
`ifdef SEQ_SHIFTER_FLAGS_EN
        .carry(s3_carry), .zero(s3_zero),
`endif
        .busy(s3_busy)
    );

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   rdy_mode = 2;
    logic prev_vld = 1'b0;
    logic prev_hs  = 1'b0;
    logic [7:0] prev_r = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: whole-operand arithmetic on the original operand, no per-step iteration.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] av, input logic [2:0] bv, input int step);
        exp_t e;
        int s;
        logic [15:0] wide;
        logic signed [7:0] sa;
        s    = int'(bv);
        e.r  = av;
        e.c  = 1'b0;
        e.acc = 0;
        case (o)
            3'd0: begin wide = {8'h00, av} << s; e.r = wide[7:0]; e.c = wide[8]; end
            3'd1: begin e.r = av >> s; if (s > 0) e.c = av[s-1]; end
            3'd2: begin sa = av; e.r = 8'(sa >>> s); if (s > 0) e.c = av[s-1]; end
            3'd3: begin wide = {av, av} << s; e.r = wide[15:8]; e.c = e.r[0]; end
            3'd4: begin wide = {av, av} >> s; e.r = wide[7:0]; e.c = e.r[7]; end
            default: e.r = av;
        endcase
        if (s == 0 || o > 3'd4) begin
            e.c   = 1'b0;
            e.lat = 1;
        end else begin
            e.lat = 1 + (s + step - 1) / step;
        end
        e.z = (e.r == 8'h00);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            if (out_valid) begin
                if (prev_hs) chk("vld_drop_after_hs", 32'(out_valid), 32'd0);
                if (!prev_vld || prev_hs) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got r=0x%0h, expected no output", r);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("result", 32'(r), 32'(mon_e.r));
                        chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
`ifdef SEQ_SHIFTER_FLAGS_EN
                        chk("carry", 32'(carry), 32'(mon_e.c));
                        chk("zero", 32'(zero), 32'(mon_e.z));
`endif
                    end
                end else begin
                    chk("r_stable", 32'(r), 32'(prev_r));
                end
            end
            prev_vld = out_valid;
            prev_hs  = out_valid && out_ready;
            prev_r   = r;
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [2:0] bv);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e     = model(o, av, bv, 1);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic run3(input logic [2:0] o, input logic [7:0] av, input logic [2:0] bv);
        exp_t e;
        int   start;
        int   n;
        n = 0;
        e = model(o, av, bv, 3);
        @(negedge clk);
        chk("s3_in_ready", 32'(s3_in_ready), 32'd1);
        s3_op = o; s3_a = av; s3_b = bv; s3_in_valid = 1'b1;
        start = cyc + 1;
        @(posedge clk);
        #1;
        s3_in_valid = 1'b0;
        s3_a = 8'($urandom);
        while (!s3_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s3_result", 32'(s3_r), 32'(e.r));
        chk("s3_latency", 32'(cyc - start), 32'(e.lat));
`ifdef SEQ_SHIFTER_FLAGS_EN
        chk("s3_carry", 32'(s3_carry), 32'(e.c));
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 3'd0;
        s3_in_valid = 1'b0; s3_op = 3'd0; s3_a = 8'h00; s3_b = 3'd0; s3_out_ready = 1'b1;
        @(negedge clk);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        rdy_mode = 2;
        send(3'd0, 8'hB5, 3'd3);
        send(3'd2, 8'h90, 3'd2);
        send(3'd1, 8'h90, 3'd2);
        send(3'd4, 8'h01, 3'd7);
        send(3'd3, 8'h81, 3'd1);
        send(3'd0, 8'h5A, 3'd0);
        send(3'd7, 8'h5A, 3'd0);
        send(3'd5, 8'hC3, 3'd5);
        drain();

        // Stall in DONE: result must hold and new requests must be ignored.
        rdy_mode = 1;
        send(3'd1, 8'hC3, 3'd4);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            in_valid = 1'b1; a = 8'($urandom); op = 3'($urandom); b = 3'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 2;
        drain();

        // Abort in the middle of a shift.
        send(3'd0, 8'hFF, 3'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_r", 32'(r), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);

        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom), 8'($urandom), 3'($urandom));
        end
        drain();
        rdy_mode = 2;

        run3(3'd1, 8'hFF, 3'd7);
        run3(3'd3, 8'h81, 3'd5);
        run3(3'd2, 8'h80, 3'd3);
        run3(3'd0, 8'hB5, 3'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
